// File: rtl/nf_router_req_ctrl.sv
// nanoFOX router request path: decodes the master address to a one-hot slave, forwards the request, and returns the slave ack.
// Optional slave-ack timeout is compiled in when NF_ROUTER_TIMEOUT_EN is defined.
module nf_router_req_ctrl #(
  parameter int SLAVE_N = 4,
  parameter int SEL_LSB = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr_m,
  input  logic               we_m,
  input  logic [31:0]        wd_m,
  input  logic [1:0]         size_m,
  input  logic               req_m,
  output logic               req_ack_m,
  output logic               err_m,
  output logic [31:0]        addr_s,
  output logic               we_s,
  output logic [31:0]        wd_s,
  output logic [1:0]         size_s,
  output logic [SLAVE_N-1:0] req_s,
  input  logic [SLAVE_N-1:0] req_ack_s,
  output logic [SLAVE_N-1:0] slave_sel
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, ERR = 2'd3} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_req_ack_m, w_req_ack_m_nxt;
  logic               r_err_m, w_err_m_nxt;
  logic [31:0]        r_addr_s, w_addr_s_nxt;
  logic               r_we_s, w_we_s_nxt;
  logic [31:0]        r_wd_s, w_wd_s_nxt;
  logic [1:0]         r_size_s, w_size_s_nxt;
  logic [SLAVE_N-1:0] r_req_s, w_req_s_nxt;
  logic [SLAVE_N-1:0] r_slave_sel, w_slave_sel_nxt;

  logic [1:0]         w_idx;
  logic               w_mapped;
  logic [SLAVE_N-1:0] w_onehot;
  logic               w_ack_valid;
  logic               w_timeout;

  assign w_idx       = addr_m[SEL_LSB+1:SEL_LSB];
  assign w_mapped    = ((addr_m >> (SEL_LSB + 2)) == 32'h0) && (32'(w_idx) < 32'(SLAVE_N));
  assign w_onehot    = SLAVE_N'(1'b1) << w_idx;
  // only the slave we actually addressed may complete the transaction
  assign w_ack_valid = |(req_ack_s & r_slave_sel);

`ifdef NF_ROUTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // wait counter: zero outside REQ, counts REQ cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state == REQ) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= {CNT_W{1'b0}};
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_req_ack_m_nxt = 1'b0;
    w_err_m_nxt     = 1'b0;
    w_addr_s_nxt    = r_addr_s;
    w_we_s_nxt      = r_we_s;
    w_wd_s_nxt      = r_wd_s;
    w_size_s_nxt    = r_size_s;
    w_req_s_nxt     = r_req_s;
    w_slave_sel_nxt = r_slave_sel;
    case (r_state)
      IDLE: begin
        if (req_m && w_mapped) begin
          w_addr_s_nxt    = addr_m;
          w_we_s_nxt      = we_m;
          w_wd_s_nxt      = wd_m;
          w_size_s_nxt    = size_m;
          w_req_s_nxt     = w_onehot;
          w_slave_sel_nxt = w_onehot;
          w_state_nxt     = REQ;
        end else if (req_m) begin
          w_slave_sel_nxt = {SLAVE_N{1'b0}};
          w_req_s_nxt     = {SLAVE_N{1'b0}};
          w_req_ack_m_nxt = 1'b1;
          w_err_m_nxt     = 1'b1;
          w_state_nxt     = ERR;
        end else begin
          w_req_s_nxt     = {SLAVE_N{1'b0}};
        end
      end
      REQ: begin
        // a valid ack beats a simultaneous timeout
        if (w_ack_valid) begin
          w_req_s_nxt     = {SLAVE_N{1'b0}};
          w_req_ack_m_nxt = 1'b1;
          w_state_nxt     = RESP;
        end else if (w_timeout) begin
          w_req_s_nxt     = {SLAVE_N{1'b0}};
          w_req_ack_m_nxt = 1'b1;
          w_err_m_nxt     = 1'b1;
          w_state_nxt     = ERR;
        end else begin
          w_state_nxt     = REQ;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      ERR: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_req_s_nxt = {SLAVE_N{1'b0}};
        w_state_nxt = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_ack_m <= 1'b0;
      r_err_m     <= 1'b0;
      r_addr_s    <= 32'h0;
      r_we_s      <= 1'b0;
      r_wd_s      <= 32'h0;
      r_size_s    <= 2'b00;
      r_req_s     <= {SLAVE_N{1'b0}};
      r_slave_sel <= {SLAVE_N{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_req_ack_m <= w_req_ack_m_nxt;
      r_err_m     <= w_err_m_nxt;
      r_addr_s    <= w_addr_s_nxt;
      r_we_s      <= w_we_s_nxt;
      r_wd_s      <= w_wd_s_nxt;
      r_size_s    <= w_size_s_nxt;
      r_req_s     <= w_req_s_nxt;
      r_slave_sel <= w_slave_sel_nxt;
    end
  end

  assign req_ack_m = r_req_ack_m;
  assign err_m     = r_err_m;
  assign addr_s    = r_addr_s;
  assign we_s      = r_we_s;
  assign wd_s      = r_wd_s;
  assign size_s    = r_size_s;
  assign req_s     = r_req_s;
  assign slave_sel = r_slave_sel;

endmodule

// File: tb/tb_nf_router_req_ctrl.sv
// Randomized bench for nf_router_req_ctrl with a transaction-level model; honours NF_ROUTER_TIMEOUT_EN.
module tb_nf_router_req_ctrl;
  localparam int SLAVE_N = 4;
  localparam int SEL_LSB = 16;
`ifdef NF_ROUTER_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_m, wd_m, addr_s, wd_s;
  logic        we_m, req_m, req_ack_m, err_m, we_s;
  logic [1:0]  size_m, size_s;
  logic [3:0]  req_s, req_ack_s, slave_sel;

  always #5 clk = ~clk;

  nf_router_req_ctrl #(.SLAVE_N(SLAVE_N), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .addr_m(addr_m), .we_m(we_m), .wd_m(wd_m), .size_m(size_m),
    .req_m(req_m), .req_ack_m(req_ack_m), .err_m(err_m), .addr_s(addr_s), .we_s(we_s),
    .wd_s(wd_s), .size_s(size_s), .req_s(req_s), .req_ack_s(req_ack_s), .slave_sel(slave_sel)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model: latched transaction values plus expectations for the current cycle
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wd;
  logic        m_we;
  logic [1:0]  m_size;
  logic        e_ack, e_err, e_we;
  logic [3:0]  e_req_s, e_sel;
  logic [31:0] e_addr, e_wd;
  logic [1:0]  e_size;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("req_ack_m", req_ack_m, e_ack);
      cmp("err_m", err_m, e_err);
      cmp("req_s", req_s, e_req_s);
      cmp("slave_sel", slave_sel, e_sel);
      cmp("addr_s", addr_s, e_addr);
      cmp("wd_s", wd_s, e_wd);
      cmp("we_s", we_s, e_we);
      cmp("size_s", size_s, e_size);
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic hold();
    e_ack = 1'b0; e_err = 1'b0; e_req_s = 4'b0000; e_sel = m_sel;
    e_addr = m_addr; e_wd = m_wd; e_we = m_we; e_size = m_size;
  endtask

  task automatic model_clear();
    m_sel = 4'b0000; m_addr = 32'h0; m_wd = 32'h0; m_we = 1'b0; m_size = 2'b00;
  endtask

  task automatic idle_cycle();
    cyc_start();
    req_m = 1'b0; req_ack_s = 4'b0000;
    addr_m = $urandom; wd_m = $urandom; we_m = 1'($urandom); size_m = 2'($urandom);
    hold();
  endtask

  task automatic txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                     input logic [1:0] size, input int d, input bit stray,
                     input bit use_pin, input logic [3:0] pin);
    int idx;
    bit mapped, tmo;
    int req_cycles;
    logic [3:0] oh;
    idx    = int'((addr >> SEL_LSB) % 32'd4);
    mapped = ((addr >> (SEL_LSB + 2)) == 32'h0) && (idx < SLAVE_N);
    oh     = 4'(1 << idx);
    cyc_start();
    req_m = 1'b1; addr_m = addr; we_m = we; wd_m = wd; size_m = size; req_ack_s = 4'b0000;
    hold();
    if (!mapped) begin
      cyc_start();
      m_sel = 4'b0000;
      hold(); e_ack = 1'b1; e_err = 1'b1;
      if (use_pin) begin @(negedge clk); #1; cmp("pin_unmapped_sel", slave_sel, pin); end
      return;
    end
    m_sel = oh; m_addr = addr; m_wd = wd; m_we = we; m_size = size;
`ifdef NF_ROUTER_TIMEOUT_EN
    tmo = (d + 1 > TIMEOUT);
`else
    tmo = 1'b0;
`endif
    req_cycles = tmo ? TIMEOUT : d + 1;
    for (int k = 1; k <= req_cycles; k++) begin
      cyc_start();
      addr_m = $urandom; wd_m = $urandom; we_m = 1'($urandom); size_m = 2'($urandom);
      req_ack_s = stray ? ((4'($urandom) | 4'b0001) & ~oh) : 4'b0000;
      if (k == d + 1) req_ack_s = req_ack_s | oh;
      hold(); e_req_s = oh;
      if (use_pin && k == 1) begin @(negedge clk); #1; cmp("pin_req_s", req_s, pin); end
    end
    cyc_start();
    req_ack_s = 4'b0000;
    hold(); e_ack = 1'b1; e_err = tmo;
  endtask

  initial begin
    int dsel;
    logic [31:0] a;
    rst = 1'b1; req_m = 1'b0; addr_m = 32'h0; wd_m = 32'h0; we_m = 1'b0; size_m = 2'b00;
    req_ack_s = 4'b0000;
    model_clear(); hold();
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_req_ack_m", req_ack_m, 1'b0);
    cmp("rst_req_s", req_s, 4'b0000);
    cmp("rst_addr_s", addr_s, 32'h0);
    cyc_start();
    rst = 1'b0; hold(); chk_en = 1'b1;
    idle_cycle();

    txn(32'h0001_0004, 1'b1, 32'hA5A5_5A5A, 2'd2, 0, 1'b0, 1'b1, 4'b0010);
    idle_cycle();
    txn(32'h0002_0000, 1'b0, 32'h0, 2'd2, 3, 1'b0, 1'b1, 4'b0100);
    txn(32'h1000_0000, 1'b0, 32'h0, 2'd0, 0, 1'b0, 1'b1, 4'b0000);
    txn(32'h0003_0000, 1'b1, 32'h1234_5678, 2'd1, 4, 1'b1, 1'b1, 4'b1000);
    idle_cycle();

    // reset asserted in the middle of REQ
    chk_en = 1'b0;
    cyc_start();
    req_m = 1'b1; addr_m = 32'h0003_0000; req_ack_s = 4'b0000;
    cyc_start();
    cmp("pre_rst_req_s", req_s, 4'b1000);
    #1 rst = 1'b1;
    #1;
    cmp("midrst_req_s", req_s, 4'b0000);
    cmp("midrst_slave_sel", slave_sel, 4'b0000);
    cmp("midrst_addr_s", addr_s, 32'h0);
    cmp("midrst_req_ack_m", req_ack_m, 1'b0);
    cyc_start();
    rst = 1'b0; req_m = 1'b0;
    model_clear(); hold(); chk_en = 1'b1;
    repeat (3) idle_cycle();

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) < 7) a = {14'b0, 2'($urandom), 16'($urandom)};
      else a = $urandom | 32'h0004_0000;
      dsel = $urandom_range(0, 7);
      txn(a, 1'($urandom), $urandom, 2'($urandom_range(0, 2)),
          (dsel == 6) ? 7 : (dsel == 7) ? 12 : dsel, 1'($urandom), 1'b0, 4'b0000);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();
    @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
